svm_data_addr_gen: RTL and testbench

//  Downstream consumer of the config register block. On each start it snapshots TRAIN_DATA_BASE, WEIGTHS_BASE_ADDR,
//  NUM_DIM and NUM_DATA_POINTS, then emits a byte-address read stream over a valid/ready handshake:
//  NUM_DIM weight words first, then NUM_DIM feature words for each data point (points stored consecutively).
//  It pulses batch_comp_done, which feeds the config block's comp-done register, when the pass finishes.

---
 rtl/svm_data_addr_gen.sv | 114 +++++++++++
 tb/tb_svm_data_addr_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_data_addr_gen.sv
// Walks the weight vector and then every training point, emitting one byte read address per handshake.
// Latency: first address one cycle after an accepted start; one word per cycle while rd_rdy stays high.
// Backpressure: rd_addr and tags hold while rd_vld && !rd_rdy; abort or rst are the only ways to drop rd_vld early.
module svm_data_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_done,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       TRAIN_DATA_BASE,
  input  logic [31:0]       WEIGTHS_BASE_ADDR,
  input  logic [31:0]       NUM_DIM,
  input  logic [31:0]       NUM_DATA_POINTS,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_is_wgt,
  output logic [CNT_W-1:0]  rd_dim,
  output logic [CNT_W-1:0]  rd_pt,
  output logic              rd_last,
  output logic              busy,
  output logic              batch_comp_done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, WGT, DATA, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] tbase_q, addr_q;
  logic [CNT_W-1:0]  ndim_q, npts_q, dim_q, pt_q;
  logic              err_q;
  logic              accept, cfg_bad, xfer, dim_end, pt_end;

  // abort in IDLE also suppresses a simultaneous start
  assign accept  = start && cfg_done && !abort && (state == IDLE);
  assign cfg_bad = (NUM_DIM == 32'd0) || (NUM_DATA_POINTS == 32'd0) ||
                   ((NUM_DIM >> CNT_W) != 32'd0) || ((NUM_DATA_POINTS >> CNT_W) != 32'd0);
  assign xfer    = rd_vld && rd_rdy;
  assign dim_end = (dim_q == ndim_q - CNT_W'(1));
  assign pt_end  = (pt_q == npts_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !cfg_bad) state_nxt = WGT;
      WGT:  if (xfer && dim_end) state_nxt = DATA;
      DATA: if (xfer && dim_end && pt_end) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbase_q <= '0;
      addr_q  <= '0;
      ndim_q  <= '0;
      npts_q  <= '0;
      dim_q   <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && cfg_bad;
      if (accept && !cfg_bad) begin
        addr_q  <= WEIGTHS_BASE_ADDR[ADDR_W-1:0];
        tbase_q <= TRAIN_DATA_BASE[ADDR_W-1:0];
        ndim_q  <= NUM_DIM[CNT_W-1:0];
        npts_q  <= NUM_DATA_POINTS[CNT_W-1:0];
        dim_q   <= '0;
        pt_q    <= '0;
      end else if (xfer) begin
        if (state == WGT) begin
          // feature stream starts fresh at the latched data base
          if (dim_end) begin
            dim_q  <= '0;
            addr_q <= tbase_q;
          end else begin
            dim_q  <= dim_q + CNT_W'(1);
            addr_q <= addr_q + ADDR_W'(WORD_BYTES);
          end
        end else begin
          addr_q <= addr_q + ADDR_W'(WORD_BYTES);
          if (dim_end) begin
            dim_q <= '0;
            pt_q  <= pt_q + CNT_W'(1);
          end else begin
            dim_q <= dim_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign rd_vld          = (state == WGT) || (state == DATA);
  assign rd_is_wgt       = (state == WGT);
  assign rd_addr         = addr_q;
  assign rd_dim          = dim_q;
  assign rd_pt           = pt_q;
  assign rd_last         = (state == DATA) && dim_end && pt_end;
  assign busy            = (state != IDLE);
  assign batch_comp_done = (state == DONE) || err_q;
  assign cfg_err         = err_q;

endmodule

// File: tb/tb_svm_data_addr_gen.sv
// Scoreboard bench for svm_data_addr_gen: stimulus pushes expected words and completion pulses,
// a negedge monitor pops and compares on every handshake and every batch_comp_done.
module tb_svm_data_addr_gen;

  logic        clk = 1'b0;
  logic        rst, cfg_done, start, abort, rd_rdy;
  logic [31:0] TRAIN_DATA_BASE, WEIGTHS_BASE_ADDR, NUM_DIM, NUM_DATA_POINTS;
  logic        rd_vld, rd_is_wgt, rd_last, busy, batch_comp_done, cfg_err;
  logic [31:0] rd_addr;
  logic [15:0] rd_dim, rd_pt;

  svm_data_addr_gen dut (
    .clk(clk), .rst(rst), .cfg_done(cfg_done), .start(start), .abort(abort),
    .TRAIN_DATA_BASE(TRAIN_DATA_BASE), .WEIGTHS_BASE_ADDR(WEIGTHS_BASE_ADDR),
    .NUM_DIM(NUM_DIM), .NUM_DATA_POINTS(NUM_DATA_POINTS),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr), .rd_is_wgt(rd_is_wgt),
    .rd_dim(rd_dim), .rd_pt(rd_pt), .rd_last(rd_last), .busy(busy),
    .batch_comp_done(batch_comp_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wgt;
    logic [15:0] dim;
    logic [15:0] pt;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  bit   done_q[$];   // 1 = completion must carry cfg_err
  int   checks = 0;
  int   errors = 0;
  bit   rand_mode = 0;
  bit   last_pend = 0;
  exp_t got, e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_addr"}, rd_addr, 32'd0);
    chk({pfx, "_tags"}, {rd_dim, rd_pt}, 32'd0);
    chk({pfx, "_flags"}, {26'd0, rd_vld, rd_is_wgt, rd_last, busy, batch_comp_done, cfg_err}, 32'd0);
  endtask

  task automatic push_pass(input logic [31:0] wb, input logic [31:0] tb, input int nd, input int np,
                           input int maxn, input bit with_done);
    exp_t x;
    int   k = 0;
    for (int d = 0; d < nd; d++) begin
      if (k < maxn) begin
        x.addr = wb + 32'(d * 4); x.wgt = 1'b1; x.dim = 16'(d); x.pt = 16'd0; x.last = 1'b0;
        exp_q.push_back(x);
        k++;
      end
    end
    for (int p = 0; p < np; p++) begin
      for (int d = 0; d < nd; d++) begin
        if (k < maxn) begin
          x.addr = tb + 32'((p * nd + d) * 4); x.wgt = 1'b0; x.dim = 16'(d); x.pt = 16'(p);
          x.last = (p == np - 1) && (d == nd - 1);
          exp_q.push_back(x);
          k++;
        end
      end
    end
    if (with_done) done_q.push_back(1'b0);
  endtask

  task automatic do_start(input logic [31:0] wb, input logic [31:0] tb, input logic [31:0] nd,
                          input logic [31:0] np);
    WEIGTHS_BASE_ADDR = wb; TRAIN_DATA_BASE = tb; NUM_DIM = nd; NUM_DATA_POINTS = np;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string name, output int n);
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d words and %0d completions still pending", name, exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
  endtask

  // ready source: held high or pseudo-random
  initial begin
    rd_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      rd_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (last_pend) begin
      checks++;
      if (!(batch_comp_done && !rd_vld)) begin
        errors++;
        $display("FAIL done_after_last: done=%b vld=%b, need done=1 vld=0", batch_comp_done, rd_vld);
      end
      last_pend = 0;
    end
    if (!rst && rd_vld && rd_rdy) begin
      got = {rd_addr, rd_is_wgt, rd_dim, rd_pt, rd_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer: addr=%h wgt=%b dim=%0d pt=%0d", rd_addr, rd_is_wgt, rd_dim, rd_pt);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL xfer: got addr=%h wgt=%b dim=%0d pt=%0d last=%b, need addr=%h wgt=%b dim=%0d pt=%0d last=%b",
                   got.addr, got.wgt, got.dim, got.pt, got.last, e.addr, e.wgt, e.dim, e.pt, e.last);
        end
      end
      if (rd_last && !abort) last_pend = 1;
    end
    if (!rst && batch_comp_done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: cfg_err=%b", cfg_err);
      end else if (cfg_err !== done_q.pop_front()) begin
        errors++;
        $display("FAIL done_kind: cfg_err=%b differs from expected", cfg_err);
      end
    end else if (!rst && cfg_err) begin
      checks++; errors++;
      $display("FAIL cfg_err_alone: cfg_err=1 with batch_comp_done=0");
    end
  end

  initial begin
    int n;
    rst = 1'b1; cfg_done = 1'b1; start = 1'b0; abort = 1'b0;
    TRAIN_DATA_BASE = '0; WEIGTHS_BASE_ADDR = '0; NUM_DIM = '0; NUM_DATA_POINTS = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    // 1: full pass at full throughput
    push_pass(32'd96, 32'd0, 2, 12, 1000, 1'b1);
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    wait_drain("t1", n);
    chk("t1_cycles", n, 32'd27);

    // 2: same pass under random backpressure
    rand_mode = 1;
    push_pass(32'd96, 32'd0, 2, 12, 1000, 1'b1);
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    wait_drain("t2", n);
    rand_mode = 0;

    // 3: rejected configurations
    done_q.push_back(1'b1);
    do_start(32'd96, 32'd0, 32'd0, 32'd12);
    wait_drain("t3a", n);
    chk("t3a_latency", n, 32'd1);
    chk("t3a_idle", {30'd0, rd_vld, busy}, 32'd0);
    done_q.push_back(1'b1);
    do_start(32'd96, 32'd0, 32'd2, 32'd70000);
    wait_drain("t3b", n);
    chk("t3b_latency", n, 32'd1);
    chk("t3b_idle", {30'd0, rd_vld, busy}, 32'd0);

    // 4: feature address wraps past the top of memory
    push_pass(32'h100, 32'hFFFF_FFF8, 3, 1, 1000, 1'b1);
    do_start(32'h100, 32'hFFFF_FFF8, 32'd3, 32'd1);
    wait_drain("t4", n);

    // 5: abort while the 6th word transfers, then restart
    push_pass(32'd96, 32'd0, 2, 12, 6, 1'b0);
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("t5_after_abort", {30'd0, rd_vld, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("t5_pending", exp_q.size(), 32'd0);
    push_pass(32'd96, 32'd0, 2, 12, 1000, 1'b1);
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    wait_drain("t5_restart", n);
    chk("t5_restart_cycles", n, 32'd27);

    // 6a: start mid-pass with new config, and start during DONE, are both ignored
    push_pass(32'd96, 32'd0, 2, 12, 1000, 1'b1);
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    repeat (3) @(posedge clk);
    #1 begin
      WEIGTHS_BASE_ADDR = 32'h4000; TRAIN_DATA_BASE = 32'h8000; NUM_DIM = 32'd5; NUM_DATA_POINTS = 32'd3;
      start = 1'b1;
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (22) @(posedge clk);
    #1 begin
      chk("t6_in_done", {30'd0, busy, batch_comp_done}, 32'd3);
      start = 1'b1;
    end
    @(posedge clk); #1 start = 1'b0;
    wait_drain("t6a", n);
    repeat (3) @(posedge clk);
    #1 chk("t6_done_start_ignored", {30'd0, rd_vld, busy}, 32'd0);

    // 6b: start with cfg_done low
    cfg_done = 1'b0;
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    repeat (3) @(posedge clk);
    #1 chk("t6_cfg_low_ignored", {30'd0, rd_vld, busy}, 32'd0);
    cfg_done = 1'b1;

    // 6c: reset in the middle of a pass
    push_pass(32'd96, 32'd0, 2, 12, 4, 1'b0);
    do_start(32'd96, 32'd0, 32'd2, 32'd12);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 chk_zero("midrst");
    chk("midrst_pending", exp_q.size(), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("midrst_idle", {30'd0, rd_vld, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
